shift_arbiter: RTL and testbench

Shares one 16-bit shifter (rotate-left, shift-left-logical, rotate-right, shift-right-arithmetic, 4-bit count) between two requesters. Each requester presents an operand, count and opcode under a valid/ready handshake. The arbiter grants one request per cycle, computes the result combinationally, and captures it in a single-entry output register with its own valid/ready handshake and backpressure. It sits between the decode/execute front end and any secondary client that needs the shift unit, such as an address-generation helper.

---
 rtl/shift_arbiter_if.sv | 48 ++++
 rtl/shift_arbiter.sv | 122 ++++++++++++
 tb/tb_shift_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if
//   Bundles the two requester handshakes and the response handshake of
//   shift_arbiter.
//   slave  : the arbiter side. It takes req*_valid/in/cnt/op and rsp_ready,
//            and drives req*_ready and rsp_valid/out/id.
//   master : the environment side. It drives the requests and rsp_ready.
//   Signals:
//     reqN_valid/ready  request handshake for requester N (N = 0, 1)
//     reqN_in[15:0]     operand
//     reqN_cnt[3:0]     shift amount
//     reqN_op[1:0]      00 rol, 01 sll, 10 ror, 11 sra
//     rsp_valid/ready   response handshake
//     rsp_out[15:0]     registered shift result
//     rsp_id            index of the requester that produced rsp_out
interface shift_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_in;
  logic [3:0]  req0_cnt;
  logic [1:0]  req0_op;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_in;
  logic [3:0]  req1_cnt;
  logic [1:0]  req1_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_out;
  logic        rsp_id;

  modport slave (
    input  req0_valid, req0_in, req0_cnt, req0_op,
    output req0_ready,
    input  req1_valid, req1_in, req1_cnt, req1_op,
    output req1_ready,
    output rsp_valid, rsp_out, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_in, req0_cnt, req0_op,
    input  req0_ready,
    output req1_valid, req1_in, req1_cnt, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_out, rsp_id,
    output rsp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Shares one 16-bit shifter (rol, sll, ror, sra; 4-bit count) between two
//   requesters. It grants at most one request per cycle and captures the
//   result in a single-entry output register.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous, active-high reset
//     bus  shift_arbiter_if.slave (request and response handshakes)
//   Configuration:
//     SHIFT_ARB_RR_EN  defined   -> round-robin between requesters
//                      undefined -> fixed priority, requester 0 wins
//
// Handshake: a transfer happens on any channel in a cycle where valid and
// ready are both high at the rising edge. reqN_ready is combinational from
// reqN_valid and rsp_ready, and is never high during reset. A held result
// (rsp_valid=1, rsp_ready=0) keeps rsp_out/rsp_id/rsp_valid stable.
module shift_arbiter (
  input  logic            clk,
  input  logic            rst,
  shift_arbiter_if.slave  bus
);

  logic        rsp_valid_q;
  logic [15:0] rsp_out_q;
  logic        rsp_id_q;

  logic        pri;
  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        xfer0;
  logic        xfer1;
  logic [15:0] sel_in;
  logic [3:0]  sel_cnt;
  logic [1:0]  sel_op;
  logic [15:0] shift_res;

  // Rotates are taken from a doubled operand so the wrapped bits fall into
  // the kept half. cnt=0 naturally passes the operand through.
  function automatic logic [15:0] shift16(input logic [15:0] x,
                                          input logic [3:0]  c,
                                          input logic [1:0]  op);
    logic [31:0] dbl;
    logic [15:0] res;
    dbl = {x, x};
    case (op)
      2'b00: begin
        dbl = dbl << c;
        res = dbl[31:16];
      end
      2'b01: res = x << c;
      2'b10: begin
        dbl = dbl >> c;
        res = dbl[15:0];
      end
      default: res = $signed(x) >>> c;
    endcase
    return res;
  endfunction

  // The slot can take a new result if it is empty or drained this cycle.
  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  // pri selects the winner when both requesters are valid.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !pri);
  assign grant1 = bus.req1_valid && (!bus.req0_valid ||  pri);

  assign bus.req0_ready = can_accept && grant0 && !rst;
  assign bus.req1_ready = can_accept && grant1 && !rst;

  assign xfer0 = bus.req0_valid && bus.req0_ready;
  assign xfer1 = bus.req1_valid && bus.req1_ready;

  always_comb begin
    sel_in  = bus.req0_in;
    sel_cnt = bus.req0_cnt;
    sel_op  = bus.req0_op;
    if (xfer1) begin
      sel_in  = bus.req1_in;
      sel_cnt = bus.req1_cnt;
      sel_op  = bus.req1_op;
    end
  end

  assign shift_res = shift16(sel_in, sel_cnt, sel_op);

`ifdef SHIFT_ARB_RR_EN
  logic pri_q;

  // After a grant the other requester is favoured on the next conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= 1'b0;
    end else if (xfer0 || xfer1) begin
      pri_q <= xfer0;
    end
  end

  assign pri = pri_q;
`else
  assign pri = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= 16'h0000;
      rsp_id_q    <= 1'b0;
    end else if (xfer0 || xfer1) begin
      rsp_valid_q <= 1'b1;
      rsp_out_q   <= shift_res;
      rsp_id_q    <= xfer1;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef SHIFT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];   // {rsp_id, rsp_out}
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_valid  = 1'b0;
  logic        m_pri    = 1'b0;
  logic        rst_seen = 1'b0;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shifter: moves the word one bit position at a time.
  function automatic logic [15:0] ref_shift(input logic [15:0] x,
                                            input logic [3:0]  c,
                                            input logic [1:0]  op);
    logic [15:0] r;
    r = x;
    for (int i = 0; i < int'(c); i++) begin
      case (op)
        2'd0: r = {r[14:0], r[15]};
        2'd1: r = {r[14:0], 1'b0};
        2'd2: r = {r[0], r[15:1]};
        default: r = {r[15], r[15:1]};
      endcase
    end
    return r;
  endfunction

  // ---------------- reference model (grant prediction) ----------------
  always @(negedge clk) begin
    logic ca, g0, g1;
    if (rst) begin
      chk("ready0_in_reset", {16'h0, bus.req0_ready}, 17'h0);
      chk("ready1_in_reset", {16'h0, bus.req1_ready}, 17'h0);
      m_valid  = 1'b0;
      m_pri    = 1'b0;
      rst_seen = 1'b1;
      exp_q.delete();
    end else begin
      chk("rsp_valid", {16'h0, bus.rsp_valid}, {16'h0, m_valid});
      if (rst_seen) begin
        chk("rsp_after_reset", {bus.rsp_id, bus.rsp_out}, 17'h0);
        rst_seen = 1'b0;
      end
      ca = !m_valid || bus.rsp_ready;
      g0 = 1'b0;
      g1 = 1'b0;
      if (ca) begin
        if (bus.req0_valid && bus.req1_valid) begin
          if (m_pri) g1 = 1'b1;
          else       g0 = 1'b1;
        end else if (bus.req0_valid) begin
          g0 = 1'b1;
        end else if (bus.req1_valid) begin
          g1 = 1'b1;
        end
      end
      chk("req0_ready", {16'h0, bus.req0_ready}, {16'h0, g0});
      chk("req1_ready", {16'h0, bus.req1_ready}, {16'h0, g1});
      if (g0) begin
        exp_q.push_back({1'b0, ref_shift(bus.req0_in, bus.req0_cnt, bus.req0_op)});
      end else if (g1) begin
        exp_q.push_back({1'b1, ref_shift(bus.req1_in, bus.req1_cnt, bus.req1_op)});
      end
      if (g0 || g1) begin
        m_valid = 1'b1;
        m_pri   = RR ? g0 : 1'b0;
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  // The held result must match the queue head every cycle it is presented;
  // it is retired only when the consumer takes it.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {bus.rsp_id, bus.rsp_out}, 17'h1FFFF);
      end else begin
        chk("rsp_data", {bus.rsp_id, bus.rsp_out}, exp_q[0]);
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [15:0] x,
                         input logic [3:0] c, input logic [1:0] op);
    if (n == 0) begin
      bus.req0_valid = 1'b1;
      bus.req0_in    = x;
      bus.req0_cnt   = c;
      bus.req0_op    = op;
    end else begin
      bus.req1_valid = 1'b1;
      bus.req1_in    = x;
      bus.req1_cnt   = c;
      bus.req1_op    = op;
    end
  endtask

  // One request from a single requester with the consumer ready; the result
  // must be visible one cycle later.
  task automatic direct(input int n, input logic [15:0] x, input logic [3:0] c,
                        input logic [1:0] op, input logic [15:0] want);
    idle_inputs();
    bus.rsp_ready = 1'b1;
    set_req(n, x, c, op);
    next_cycle();
    idle_inputs();
    chk("dir_valid", {16'h0, bus.rsp_valid}, 17'h1);
    chk("dir_result", {bus.rsp_id, bus.rsp_out}, {n[0], want});
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_in    = '0;
    bus.req0_cnt   = '0;
    bus.req0_op    = '0;
    bus.req1_valid = 1'b0;
    bus.req1_in    = '0;
    bus.req1_cnt   = '0;
    bus.req1_op    = '0;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    next_cycle();

    // Directed opcode cases, including a back-to-back drain+accept.
    direct(0, 16'h8001, 4'd1,  2'd0, 16'h0003);
    direct(1, 16'h00FF, 4'd4,  2'd1, 16'h0FF0);
    direct(0, 16'h0001, 4'd1,  2'd2, 16'h8000);
    direct(1, 16'h8000, 4'd15, 2'd3, 16'hFFFF);
    for (int k = 0; k < 4; k++) direct(k % 2, 16'hA5C3, 4'd0, k[1:0], 16'hA5C3);
    direct(1, 16'h8421, 4'd15, 2'd0, 16'hC210);
    direct(0, 16'h7FFF, 4'd15, 2'd3, 16'h0000);

    // Both requesters valid continuously from reset.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 16'($urandom), 4'($urandom), 2'($urandom));
      set_req(1, 16'($urandom), 4'($urandom), 2'($urandom));
      next_cycle();
      chk("conflict_id", {16'h0, bus.rsp_id}, {16'h0, (RR ? i[0] : 1'b0)});
    end

    // Backpressure: hold the first result, then release.
    idle_inputs();
    next_cycle();
    set_req(0, 16'h1234, 4'd3, 2'd0);
    set_req(1, 16'hF00F, 4'd2, 2'd3);
    next_cycle();
    bus.rsp_ready = 1'b0;
    repeat (3) next_cycle();
    bus.rsp_ready = 1'b1;
    next_cycle();
    idle_inputs();
    chk("bp_release_valid", {16'h0, bus.rsp_valid}, 17'h1);
    next_cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req0_in    = 16'($urandom);
      bus.req0_cnt   = 4'($urandom_range(0, 15));
      bus.req0_op    = 2'($urandom_range(0, 3));
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req1_in    = 16'($urandom);
      bus.req1_cnt   = 4'($urandom_range(0, 15));
      bus.req1_op    = 2'($urandom_range(0, 3));
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      next_cycle();
    end

    // Reset while a result is held and both requesters are valid.
    idle_inputs();
    bus.rsp_ready = 1'b0;
    set_req(1, 16'h0F0F, 4'd4, 2'd2);
    next_cycle();
    set_req(0, 16'h0003, 4'd2, 2'd1);
    set_req(1, 16'hC000, 4'd1, 2'd3);
    chk("pre_reset_valid", {16'h0, bus.rsp_valid}, 17'h1);
    pulse_reset();
    chk("reset_clears", {bus.rsp_valid, bus.rsp_out}, 17'h0);
    bus.rsp_ready = 1'b1;
    next_cycle();
    chk("first_after_reset", {bus.rsp_id, bus.rsp_out}, {1'b0, 16'h000C});

    // Drain and finish.
    idle_inputs();
    bus.rsp_ready = 1'b1;
    repeat (3) next_cycle();
    chk("queue_empty", 17'(exp_q.size()), 17'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
